// File: rtl/alu_issue_stage.sv
// alu_issue_stage: ID register, decode to one-hot ALU opcode/operands, RAW hazard handling.
// Macro ID_BYPASS_EN selects forwarding (stall only on load-use); default stalls on any match.
module alu_issue_stage (
    input  logic        clk,
    input  logic        resetn,
    input  logic        fs_to_ds_valid,
    input  logic [31:0] fs_inst,
    input  logic [31:0] fs_pc,
    output logic        ds_allowin,
    output logic [4:0]  rf_raddr1,
    output logic [4:0]  rf_raddr2,
    input  logic [31:0] rf_rdata1,
    input  logic [31:0] rf_rdata2,
    input  logic        es_allowin,
    output logic        ds_to_es_valid,
    output logic [11:0] es_alu_op,
    output logic [31:0] es_alu_src1,
    output logic [31:0] es_alu_src2,
    output logic [4:0]  es_dest,
    output logic [31:0] es_pc,
    input  logic        es_wb_valid,
    input  logic [4:0]  es_wb_dest,
    input  logic        es_is_load,
    input  logic [31:0] es_fwd_data,
    input  logic        ms_wb_valid,
    input  logic [4:0]  ms_wb_dest,
    input  logic [31:0] ms_fwd_data,
    input  logic        ws_wb_valid,
    input  logic [4:0]  ws_wb_dest,
    input  logic [31:0] ws_fwd_data
);

    typedef enum logic [1:0] {SRC1_RS, SRC1_SA, SRC1_ZERO} src1_sel_e;
    typedef enum logic [1:0] {SRC2_RT, SRC2_SIMM, SRC2_ZIMM, SRC2_ZERO} src2_sel_e;

    logic        ds_valid_q, ds_valid_d;
    logic [31:0] ds_inst_q, ds_inst_d;
    logic [31:0] ds_pc_q, ds_pc_d;
    logic        stall, ds_ready_go;

    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd, sa;
    logic [15:0] imm;
    logic [11:0] alu_op;
    logic [4:0]  dest;
    logic        use_rs, use_rt;
    src1_sel_e   src1_sel;
    src2_sel_e   src2_sel;
    logic [31:0] rs_val, rt_val, src1_val, src2_val;
    logic        rs_es, rs_ms, rs_ws, rt_es, rt_ms, rt_ws;

    assign opcode = ds_inst_q[31:26];
    assign rs     = ds_inst_q[25:21];
    assign rt     = ds_inst_q[20:16];
    assign rd     = ds_inst_q[15:11];
    assign sa     = ds_inst_q[10:6];
    assign funct  = ds_inst_q[5:0];
    assign imm    = ds_inst_q[15:0];

    assign rf_raddr1 = rs;
    assign rf_raddr2 = rt;

    always_comb begin
        alu_op   = '0;
        dest     = '0;
        use_rs   = 1'b0;
        use_rt   = 1'b0;
        src1_sel = SRC1_ZERO;
        src2_sel = SRC2_ZERO;
        case (opcode)
            6'h00: begin
                dest     = rd;
                use_rt   = 1'b1;
                src2_sel = SRC2_RT;
                if (funct == 6'h00 || funct == 6'h02 || funct == 6'h03) begin
                    src1_sel = SRC1_SA;
                end else begin
                    use_rs   = 1'b1;
                    src1_sel = SRC1_RS;
                end
                case (funct)
                    6'h21:   alu_op[0]  = 1'b1;
                    6'h23:   alu_op[1]  = 1'b1;
                    6'h2a:   alu_op[2]  = 1'b1;
                    6'h2b:   alu_op[3]  = 1'b1;
                    6'h24:   alu_op[4]  = 1'b1;
                    6'h27:   alu_op[5]  = 1'b1;
                    6'h25:   alu_op[6]  = 1'b1;
                    6'h26:   alu_op[7]  = 1'b1;
                    6'h00:   alu_op[8]  = 1'b1;
                    6'h02:   alu_op[9]  = 1'b1;
                    6'h03:   alu_op[10] = 1'b1;
                    default: ;
                endcase
            end
            6'h09, 6'h0a, 6'h0b: begin
                dest     = rt;
                use_rs   = 1'b1;
                src1_sel = SRC1_RS;
                src2_sel = SRC2_SIMM;
                alu_op[0] = (opcode == 6'h09);
                alu_op[2] = (opcode == 6'h0a);
                alu_op[3] = (opcode == 6'h0b);
            end
            6'h0c, 6'h0d, 6'h0e: begin
                dest     = rt;
                use_rs   = 1'b1;
                src1_sel = SRC1_RS;
                src2_sel = SRC2_ZIMM;
                alu_op[4] = (opcode == 6'h0c);
                alu_op[6] = (opcode == 6'h0d);
                alu_op[7] = (opcode == 6'h0e);
            end
            6'h0f: begin
                dest       = rt;
                src2_sel   = SRC2_ZIMM;
                alu_op[11] = 1'b1;
            end
            default: ;
        endcase
    end

    // A source only matches a producer when it is actually read and is not $0.
    function automatic logic hit(input logic used, input logic [4:0] src,
                                 input logic prod_valid, input logic [4:0] prod_dest);
        return used && (src != 5'd0) && prod_valid && (src == prod_dest);
    endfunction

    assign rs_es = hit(use_rs, rs, es_wb_valid, es_wb_dest);
    assign rs_ms = hit(use_rs, rs, ms_wb_valid, ms_wb_dest);
    assign rs_ws = hit(use_rs, rs, ws_wb_valid, ws_wb_dest);
    assign rt_es = hit(use_rt, rt, es_wb_valid, es_wb_dest);
    assign rt_ms = hit(use_rt, rt, ms_wb_valid, ms_wb_dest);
    assign rt_ws = hit(use_rt, rt, ws_wb_valid, ws_wb_dest);

`ifdef ID_BYPASS_EN
    assign stall  = (rs_es | rt_es) & es_is_load;
    assign rs_val = rs_es ? es_fwd_data : rs_ms ? ms_fwd_data : rs_ws ? ws_fwd_data : rf_rdata1;
    assign rt_val = rt_es ? es_fwd_data : rt_ms ? ms_fwd_data : rt_ws ? ws_fwd_data : rf_rdata2;
`else
    logic unused_fwd;
    assign unused_fwd = ^{es_fwd_data, ms_fwd_data, ws_fwd_data, es_is_load};
    assign stall  = rs_es | rs_ms | rs_ws | rt_es | rt_ms | rt_ws;
    assign rs_val = rf_rdata1;
    assign rt_val = rf_rdata2;
`endif

    always_comb begin
        case (src1_sel)
            SRC1_RS: src1_val = rs_val;
            SRC1_SA: src1_val = {27'b0, sa};
            default: src1_val = '0;
        endcase
        case (src2_sel)
            SRC2_RT:   src2_val = rt_val;
            SRC2_SIMM: src2_val = {{16{imm[15]}}, imm};
            SRC2_ZIMM: src2_val = {16'b0, imm};
            default:   src2_val = '0;
        endcase
    end

    assign ds_ready_go    = ~stall;
    assign ds_allowin     = ~ds_valid_q | (ds_ready_go & es_allowin);
    assign ds_to_es_valid = ds_valid_q & ds_ready_go;

    assign es_alu_op   = ds_valid_q ? alu_op   : '0;
    assign es_dest     = ds_valid_q ? dest     : '0;
    assign es_alu_src1 = ds_valid_q ? src1_val : '0;
    assign es_alu_src2 = ds_valid_q ? src2_val : '0;
    assign es_pc       = ds_pc_q;

    always_comb begin
        ds_valid_d = ds_valid_q;
        ds_inst_d  = ds_inst_q;
        ds_pc_d    = ds_pc_q;
        if (ds_allowin) begin
            ds_valid_d = fs_to_ds_valid;
            if (fs_to_ds_valid) begin
                ds_inst_d = fs_inst;
                ds_pc_d   = fs_pc;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ds_valid_q <= 1'b0;
            ds_inst_q  <= '0;
            ds_pc_q    <= '0;
        end else begin
            ds_valid_q <= ds_valid_d;
            ds_inst_q  <= ds_inst_d;
            ds_pc_q    <= ds_pc_d;
        end
    end

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: directed and randomized checks of alu_issue_stage against an encoder-side model.
// Expectations follow ID_BYPASS_EN when the bench is built with that macro.
module tb_alu_issue_stage;

    logic        clk = 1'b0;
    logic        resetn;
    logic        fs_to_ds_valid;
    logic [31:0] fs_inst, fs_pc;
    logic        ds_allowin;
    logic [4:0]  rf_raddr1, rf_raddr2;
    logic [31:0] rf_rdata1, rf_rdata2;
    logic        es_allowin;
    logic        ds_to_es_valid;
    logic [11:0] es_alu_op;
    logic [31:0] es_alu_src1, es_alu_src2;
    logic [4:0]  es_dest;
    logic [31:0] es_pc;
    logic        es_wb_valid, es_is_load, ms_wb_valid, ws_wb_valid;
    logic [4:0]  es_wb_dest, ms_wb_dest, ws_wb_dest;
    logic [31:0] es_fwd_data, ms_fwd_data, ws_fwd_data;

    logic [31:0] rf [32];

    typedef struct packed {
        logic [11:0] op;
        logic [31:0] s1;
        logic [31:0] s2;
        logic [4:0]  dest;
        logic [31:0] pc;
        logic        chkSrc;
    } exp_t;

    // Kind numbering: 0..10 addu subu slt sltu and or xor nor sll srl sra,
    // 11..17 addiu slti sltiu andi ori xori lui, 18 unsupported opcode 0x3F.
    localparam logic [5:0] FUNCT_TAB [11] = '{6'h21, 6'h23, 6'h2a, 6'h2b, 6'h24, 6'h25,
                                              6'h26, 6'h27, 6'h00, 6'h02, 6'h03};
    localparam int R_BIT [11] = '{0, 1, 2, 3, 4, 6, 7, 5, 8, 9, 10};
    localparam int I_BIT [7]  = '{0, 2, 3, 4, 6, 7, 11};

    exp_t        expQ[$];
    exp_t        fsExp;
    logic        sbEnable;
    logic [31:0] pcNext;
    int          passCount = 0;
    int          failCount = 0;
    int          checkCount = 0;
    int          sentCount = 0;
    int          issuedCount = 0;

    always #5 clk = ~clk;

    assign rf_rdata1 = rf[rf_raddr1];
    assign rf_rdata2 = rf[rf_raddr2];

    alu_issue_stage dut (
        .clk(clk), .resetn(resetn),
        .fs_to_ds_valid(fs_to_ds_valid), .fs_inst(fs_inst), .fs_pc(fs_pc),
        .ds_allowin(ds_allowin),
        .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
        .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .es_allowin(es_allowin), .ds_to_es_valid(ds_to_es_valid),
        .es_alu_op(es_alu_op), .es_alu_src1(es_alu_src1), .es_alu_src2(es_alu_src2),
        .es_dest(es_dest), .es_pc(es_pc),
        .es_wb_valid(es_wb_valid), .es_wb_dest(es_wb_dest),
        .es_is_load(es_is_load), .es_fwd_data(es_fwd_data),
        .ms_wb_valid(ms_wb_valid), .ms_wb_dest(ms_wb_dest), .ms_fwd_data(ms_fwd_data),
        .ws_wb_valid(ws_wb_valid), .ws_wb_dest(ws_wb_dest), .ws_fwd_data(ws_fwd_data)
    );

    // Builds an instruction word from its fields and the result the ALU should be handed.
    function automatic void makeInst(input int kind, input logic [4:0] rs, input logic [4:0] rt,
                                     input logic [4:0] rd, input logic [4:0] sa,
                                     input logic [15:0] imm, input logic [31:0] pc,
                                     output logic [31:0] inst, output exp_t e);
        e = '0;
        e.pc = pc;
        e.chkSrc = 1'b1;
        if (kind < 11) begin
            inst = {6'h00, rs, rt, rd, sa, FUNCT_TAB[kind]};
            e.op = 12'd1 << R_BIT[kind];
            e.dest = rd;
            e.s1 = (kind >= 8) ? {27'b0, sa} : rf[rs];
            e.s2 = rf[rt];
        end else if (kind < 18) begin
            inst = {6'(kind - 2), rs, rt, imm};
            e.op = 12'd1 << I_BIT[kind - 11];
            e.dest = rt;
            e.s1 = (kind == 17) ? 32'd0 : rf[rs];
            e.s2 = (kind <= 13) ? {{16{imm[15]}}, imm} : {16'b0, imm};
        end else begin
            inst = {6'h3f, rs, rt, imm};
            e.chkSrc = 1'b0;
        end
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [31:0] inst,
                                 input logic [31:0] pc, input logic esAllow);
        fs_to_ds_valid = valid;
        fs_inst = inst;
        fs_pc = pc;
        es_allowin = esAllow;
        #1;
    endtask

    task automatic clearProducers();
        es_wb_valid = 1'b0; es_wb_dest = 5'd0; es_is_load = 1'b0; es_fwd_data = 32'd0;
        ms_wb_valid = 1'b0; ms_wb_dest = 5'd0; ms_fwd_data = 32'd0;
        ws_wb_valid = 1'b0; ws_wb_dest = 5'd0; ws_fwd_data = 32'd0;
        #1;
    endtask

    // Scoreboard: transfers compare against the oldest accepted instruction, then advance one cycle.
    task automatic stepClock();
        exp_t e;
        if (sbEnable) begin
            if (ds_to_es_valid && es_allowin) begin
                issuedCount++;
                if (expQ.size() == 0) begin
                    checkOutput("spurious_issue", 32'(ds_to_es_valid), 32'd0);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("issue_pc", es_pc, e.pc);
                    checkOutput("issue_op", 32'(es_alu_op), 32'(e.op));
                    checkOutput("issue_dest", 32'(es_dest), 32'(e.dest));
                    if (e.chkSrc) begin
                        checkOutput("issue_src1", es_alu_src1, e.s1);
                        checkOutput("issue_src2", es_alu_src2, e.s2);
                    end
                end
            end
            if (ds_allowin && fs_to_ds_valid) begin
                expQ.push_back(fsExp);
                sentCount++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic sendInst(input int kind, input logic [4:0] rs, input logic [4:0] rt,
                            input logic [4:0] rd, input logic [4:0] sa, input logic [15:0] imm);
        logic [31:0] inst;
        exp_t e;
        makeInst(kind, rs, rt, rd, sa, imm, pcNext, inst, e);
        fsExp = e;
        applyStimulus(1'b1, inst, pcNext, 1'b1);
        pcNext += 32'd4;
        stepClock();
        applyStimulus(1'b0, inst, pcNext, 1'b1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] instA, instB, instR, pcB;
        exp_t eA, eB, eR;
        int kind;

        for (int i = 0; i < 32; i++) rf[i] = $urandom;
        rf[0] = 32'd0;
        rf[1] = 32'd5;
        rf[4] = 32'hF000_1230;
        pcNext = 32'h0000_1000;
        sbEnable = 1'b1;
        resetn = 1'b0;
        clearProducers();
        applyStimulus(1'b0, 32'd0, 32'd0, 1'b1);

        #2;
        checkOutput("rst_allowin", 32'(ds_allowin), 32'd1);
        checkOutput("rst_valid", 32'(ds_to_es_valid), 32'd0);
        checkOutput("rst_op", 32'(es_alu_op), 32'd0);
        checkOutput("rst_dest", 32'(es_dest), 32'd0);
        checkOutput("rst_src1", es_alu_src1, 32'd0);
        checkOutput("rst_pc", es_pc, 32'd0);
        #10;
        resetn = 1'b1;
        @(posedge clk);
        #1;

        // addiu $2,$1,-1 with $1 = 5
        sendInst(11, 5'd1, 5'd2, 5'd0, 5'd0, 16'hFFFF);
        checkOutput("addiu_valid", 32'(ds_to_es_valid), 32'd1);
        checkOutput("addiu_op", 32'(es_alu_op), 32'h001);
        checkOutput("addiu_src1", es_alu_src1, 32'd5);
        checkOutput("addiu_src2", es_alu_src2, 32'hFFFF_FFFF);
        checkOutput("addiu_dest", 32'(es_dest), 32'd2);
        stepClock();

        // sra $3,$4,4
        sendInst(10, 5'd0, 5'd4, 5'd3, 5'd4, 16'd0);
        checkOutput("sra_op", 32'(es_alu_op), 32'h400);
        checkOutput("sra_src1", es_alu_src1, 32'd4);
        checkOutput("sra_src2", es_alu_src2, 32'hF000_1230);
        checkOutput("sra_dest", 32'(es_dest), 32'd3);
        stepClock();

        // lui $5,0x1234 (rs field nonzero to show it is ignored)
        sendInst(17, 5'd7, 5'd5, 5'd0, 5'd0, 16'h1234);
        checkOutput("lui_op", 32'(es_alu_op), 32'h800);
        checkOutput("lui_src1", es_alu_src1, 32'd0);
        checkOutput("lui_src2", es_alu_src2, 32'h0000_1234);
        stepClock();

        // ori $6,$0,0x8000 must zero-extend
        sendInst(15, 5'd0, 5'd6, 5'd0, 5'd0, 16'h8000);
        checkOutput("ori_op", 32'(es_alu_op), 32'h040);
        checkOutput("ori_src2", es_alu_src2, 32'h0000_8000);
        checkOutput("ori_src1", es_alu_src1, 32'd0);
        stepClock();

        // Back-pressure: hold es_allowin low three cycles with a second instruction waiting.
        makeInst(4, 5'd1, 5'd4, 5'd12, 5'd0, 16'd0, pcNext, instA, eA);
        fsExp = eA;
        applyStimulus(1'b1, instA, pcNext, 1'b1);
        pcNext += 32'd4;
        stepClock();
        makeInst(6, 5'd4, 5'd1, 5'd13, 5'd0, 16'd0, pcNext, instB, eB);
        fsExp = eB;
        pcB = pcNext;
        pcNext += 32'd4;
        applyStimulus(1'b1, instB, pcB, 1'b0);
        for (int i = 0; i < 3; i++) begin
            checkOutput("bp_allowin", 32'(ds_allowin), 32'd0);
            checkOutput("bp_pc", es_pc, eA.pc);
            checkOutput("bp_op", 32'(es_alu_op), 32'(eA.op));
            stepClock();
        end
        applyStimulus(1'b1, instB, pcB, 1'b1);
        stepClock();
        applyStimulus(1'b0, instB, pcB, 1'b1);
        stepClock();

        // Random stream with random back-pressure, no producers active.
        for (int i = 0; i < 300; i++) begin
            kind = int'($urandom_range(18, 0));
            makeInst(kind, 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
                     16'($urandom), pcNext, instR, eR);
            fsExp = eR;
            applyStimulus(($urandom_range(9, 0) < 7), instR, pcNext, ($urandom_range(3, 0) != 0));
            pcNext += 32'd4;
            stepClock();
        end
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 32'd0, pcNext, 1'b1);
            stepClock();
        end
        checkOutput("drain_empty", 32'(expQ.size()), 32'd0);
        checkOutput("drain_valid", 32'(ds_to_es_valid), 32'd0);
        sbEnable = 1'b0;

        // RAW on rs from the execute stage: addu $7,$2,$0
        es_wb_valid = 1'b1; es_wb_dest = 5'd2; es_fwd_data = 32'h0000_00AB;
        sendInst(0, 5'd2, 5'd0, 5'd7, 5'd0, 16'd0);
`ifdef ID_BYPASS_EN
        checkOutput("raw_valid", 32'(ds_to_es_valid), 32'd1);
        checkOutput("raw_src1", es_alu_src1, 32'h0000_00AB);
        stepClock();
`else
        checkOutput("raw_valid", 32'(ds_to_es_valid), 32'd0);
        checkOutput("raw_allowin", 32'(ds_allowin), 32'd0);
        stepClock();
        checkOutput("raw_valid_hold", 32'(ds_to_es_valid), 32'd0);
        checkOutput("raw_pc_hold", es_pc, pcNext - 32'd4);
        clearProducers();
        checkOutput("raw_valid_clr", 32'(ds_to_es_valid), 32'd1);
        checkOutput("raw_src1_clr", es_alu_src1, rf[2]);
        stepClock();
`endif
        clearProducers();

        // Load-use on rt: addu $8,$0,$2 with a load in execute, then the value arrives from memory.
        es_wb_valid = 1'b1; es_wb_dest = 5'd2; es_is_load = 1'b1; es_fwd_data = 32'h0000_00AB;
        sendInst(0, 5'd0, 5'd2, 5'd8, 5'd0, 16'd0);
        checkOutput("lu_valid0", 32'(ds_to_es_valid), 32'd0);
        stepClock();
        clearProducers();
        ms_wb_valid = 1'b1; ms_wb_dest = 5'd2; ms_fwd_data = 32'h0000_00CD;
        #1;
`ifdef ID_BYPASS_EN
        checkOutput("lu_valid1", 32'(ds_to_es_valid), 32'd1);
        checkOutput("lu_src2", es_alu_src2, 32'h0000_00CD);
        stepClock();
`else
        checkOutput("lu_valid1", 32'(ds_to_es_valid), 32'd0);
        stepClock();
        clearProducers();
        checkOutput("lu_valid2", 32'(ds_to_es_valid), 32'd1);
        checkOutput("lu_src2", es_alu_src2, rf[2]);
        stepClock();
`endif
        clearProducers();

        // Forwarding priority on both sources: subu $9,$3,$3 held in ID by es_allowin=0.
        sendInst(1, 5'd3, 5'd3, 5'd9, 5'd0, 16'd0);
        es_allowin = 1'b0;
        es_wb_valid = 1'b1; es_wb_dest = 5'd3; es_fwd_data = 32'h1111_1111;
        ms_wb_valid = 1'b1; ms_wb_dest = 5'd3; ms_fwd_data = 32'h2222_2222;
        ws_wb_valid = 1'b1; ws_wb_dest = 5'd3; ws_fwd_data = 32'h3333_3333;
        #1;
`ifdef ID_BYPASS_EN
        checkOutput("pri_es_src1", es_alu_src1, 32'h1111_1111);
        checkOutput("pri_es_src2", es_alu_src2, 32'h1111_1111);
        es_wb_valid = 1'b0; #1;
        checkOutput("pri_ms_src1", es_alu_src1, 32'h2222_2222);
        ms_wb_valid = 1'b0; #1;
        checkOutput("pri_ws_src2", es_alu_src2, 32'h3333_3333);
        checkOutput("pri_ws_valid", 32'(ds_to_es_valid), 32'd1);
`else
        checkOutput("pri_es_valid", 32'(ds_to_es_valid), 32'd0);
        es_wb_valid = 1'b0; #1;
        checkOutput("pri_ms_valid", 32'(ds_to_es_valid), 32'd0);
        ms_wb_valid = 1'b0; #1;
        checkOutput("pri_ws_valid", 32'(ds_to_es_valid), 32'd0);
`endif
        checkOutput("pri_allowin", 32'(ds_allowin), 32'd0);
        ws_wb_valid = 1'b0; #1;
        checkOutput("pri_none_valid", 32'(ds_to_es_valid), 32'd1);
        checkOutput("pri_none_src1", es_alu_src1, rf[3]);
        es_allowin = 1'b1; #1;
        stepClock();
        clearProducers();

        // Unsupported opcode ignores a concurrent producer match.
        es_wb_valid = 1'b1; es_wb_dest = 5'd2; es_is_load = 1'b1;
        sendInst(18, 5'd2, 5'd2, 5'd0, 5'd0, 16'h1234);
        checkOutput("unsup_valid", 32'(ds_to_es_valid), 32'd1);
        checkOutput("unsup_op", 32'(es_alu_op), 32'd0);
        checkOutput("unsup_dest", 32'(es_dest), 32'd0);
        stepClock();
        clearProducers();

        // Register 0 never matches even when producers target it.
        es_wb_valid = 1'b1; es_wb_dest = 5'd0; es_is_load = 1'b1;
        ms_wb_valid = 1'b1; ws_wb_valid = 1'b1;
        sendInst(0, 5'd0, 5'd0, 5'd10, 5'd0, 16'd0);
        checkOutput("r0_valid", 32'(ds_to_es_valid), 32'd1);
        checkOutput("r0_dest", 32'(es_dest), 32'd10);
        stepClock();
        clearProducers();

        // Asynchronous reset while stalled.
        es_wb_valid = 1'b1; es_wb_dest = 5'd2; es_is_load = 1'b1;
        sendInst(0, 5'd2, 5'd0, 5'd11, 5'd0, 16'd0);
        checkOutput("rs_stall_valid", 32'(ds_to_es_valid), 32'd0);
        checkOutput("rs_stall_op", 32'(es_alu_op), 32'h001);
        resetn = 1'b0;
        #1;
        checkOutput("rs_allowin", 32'(ds_allowin), 32'd1);
        checkOutput("rs_valid", 32'(ds_to_es_valid), 32'd0);
        checkOutput("rs_op", 32'(es_alu_op), 32'd0);
        checkOutput("rs_dest", 32'(es_dest), 32'd0);
        checkOutput("rs_src1", es_alu_src1, 32'd0);
        checkOutput("rs_pc", es_pc, 32'd0);
        #1;
        resetn = 1'b1;
        clearProducers();
        stepClock();

        $display("[TB] random stream: %0d accepted, %0d issued", sentCount, issuedCount);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
